// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver:
// segment codes, converter states and the nibble decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = 7'b0000110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per cycle,
// with a guard nibble and a sticky flag for digits lost off the top.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VAL_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAL_W-1:0]      val,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int ACC_W = 4 * DIGITS + 4;
    localparam int CNT_W = $clog2(VAL_W + 1);

    conv_state_e        state_q, state_d;
    logic [VAL_W-1:0]   sh_q, sh_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               spill_q, spill_d;
    logic [ACC_W-1:0]   adj;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            spill_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            spill_q <= spill_d;
        end
    end

    always_comb begin
        adj = acc_q;
        for (int n = 0; n <= DIGITS; n++) begin
            if (acc_q[4*n +: 4] >= 4'd5)
                adj[4*n +: 4] = acc_q[4*n +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        spill_d = spill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = val;
                    acc_d   = '0;
                    cnt_d   = '0;
                    spill_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = {adj[ACC_W-2:0], sh_q[VAL_W-1]};
                sh_d    = sh_q << 1;
                spill_d = spill_q | adj[ACC_W-1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VAL_W - 1))
                    state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_COMMIT);
    // Lower nibbles are valid BCD, so any guard content means >= 10^DIGITS.
    assign ovf  = spill_q | (|acc_q[ACC_W-1 -: 4]);
    assign bcd  = acc_q[4*DIGITS-1:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver: free-running BCD
// conversion, display register, digit scanner and registered decode.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int VAL_W       = 27,
    parameter int REFRESH_DIV = 65536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  val,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [6:0]        out,
    output logic              dp,
    output logic [DIGITS-1:0] anod_select,
    output logic              busy
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                  conv_done;
    logic                  conv_ovf;
    logic [4*DIGITS-1:0]   conv_bcd;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*DIGITS-1:0]   disp_q, disp_d;
    logic                  ovf_q, ovf_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic [3:0]            nib;
    logic                  upper_nz;

    bin2bcd_seq #(
        .VAL_W  (VAL_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (1'b1),
        .val   (val),
        .busy  (busy),
        .done  (conv_done),
        .ovf   (conv_ovf),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            an_q   <= '1;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1))
                idx_d = '0;
            else
                idx_d = idx_q + 1'b1;
        end
    end

    // Overflowed results leave the last good value in the register.
    always_comb begin
        disp_d = disp_q;
        ovf_d  = ovf_q;
        if (conv_done) begin
            ovf_d = conv_ovf;
            if (!conv_ovf)
                disp_d = conv_bcd;
        end
    end

    always_comb begin
        nib      = disp_q[{idx_q, 2'b00} +: 4];
        upper_nz = 1'b0;
        for (int j = 0; j < DIGITS; j++) begin
            if (IDX_W'(j) >= idx_q && disp_q[4*j +: 4] != 4'd0)
                upper_nz = 1'b1;
        end
    end

    always_comb begin
        seg_d = seg7_decode(nib);
        dp_d  = ~dp_mask[idx_q];
        an_d  = ~(DIGITS'(1) << idx_q);
        if (ovf_q) begin
            seg_d = SEG_DASH;
            dp_d  = 1'b1;
        end else if (blank_lz && idx_q != '0 && !upper_nz) begin
            seg_d = SEG_BLANK;
        end
    end

    assign out         = seg_q;
    assign dp          = dp_q;
    assign anod_select = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-digit, 16-bit,
// fast-refresh configuration.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int VAL_W  = 16;
    localparam int RDIV   = 4;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLK  = 7'b1111111;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [VAL_W-1:0]  val = '0;
    logic              blank_lz = 1'b0;
    logic [DIGITS-1:0] dp_mask = '0;
    logic [6:0]        out;
    logic              dp;
    logic [DIGITS-1:0] anod_select;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .VAL_W       (VAL_W),
        .REFRESH_DIV (RDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .val         (val),
        .blank_lz    (blank_lz),
        .dp_mask     (dp_mask),
        .out         (out),
        .dp          (dp),
        .anod_select (anod_select),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_digit(input int i);
        logic [DIGITS-1:0] exp_an;
        int k;
        exp_an = ~(DIGITS'(1) << i);
        k = 0;
        while (anod_select !== exp_an && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (k >= 64)
            chk("digit_timeout", 32'(anod_select), 32'(exp_an));
    endtask

    task automatic chk_digit(input string tag, input int i,
                             input logic [6:0] seg, input logic d);
        wait_digit(i);
        chk({tag, "_seg"}, 32'(out), 32'(seg));
        chk({tag, "_dp"}, 32'(dp), 32'(d));
    endtask

    function automatic int an2idx(input logic [DIGITS-1:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    initial begin
        logic [6:0] e1234 [4];
        int idx;
        int k;
        e1234 = '{S4, S3, S2, S1};

        // reset state
        cyc(3);
        chk("rst_out", 32'(out), 32'(BLK));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_an", 32'(anod_select), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1 chk("rel_an_hold", 32'(anod_select), 32'hF);
        cyc(1);
        chk("rel_an_first", 32'(anod_select), 32'hE);
        chk("rel_busy", 32'(busy), 32'd1);
        chk("rel_out", 32'(out), 32'(S0));

        // 1234, scan order and hold time
        val = 16'd1234;
        cyc(40);
        chk_digit("v1234_d0", 0, S4, 1'b1);
        chk_digit("v1234_d1", 1, S3, 1'b1);
        chk_digit("v1234_d2", 2, S2, 1'b1);
        chk_digit("v1234_d3", 3, S1, 1'b1);
        wait_digit(3);
        wait_digit(0);
        for (int m = 0; m < RDIV - 1; m++) begin
            cyc(1);
            chk("hold_d0", 32'(anod_select), 32'hE);
        end
        cyc(1);
        chk("step_d1", 32'(anod_select), 32'hD);
        chk_digit("wrap_d0", 0, S4, 1'b1);

        // asynchronous reset mid-run
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out", 32'(out), 32'(BLK));
        chk("mid_rst_dp", 32'(dp), 32'd1);
        chk("mid_rst_an", 32'(anod_select), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk("mid_rel_an", 32'(anod_select), 32'hE);
        chk("mid_rel_out", 32'(out), 32'(S0));

        // leading-zero blanking
        val = 16'd7;
        blank_lz = 1'b1;
        cyc(40);
        chk_digit("lz7_d0", 0, S7, 1'b1);
        chk_digit("lz7_d1", 1, BLK, 1'b1);
        chk_digit("lz7_d2", 2, BLK, 1'b1);
        chk_digit("lz7_d3", 3, BLK, 1'b1);
        blank_lz = 1'b0;
        chk_digit("nolz7_d1", 1, S0, 1'b1);
        chk_digit("nolz7_d2", 2, S0, 1'b1);
        chk_digit("nolz7_d3", 3, S0, 1'b1);
        val = 16'd0;
        blank_lz = 1'b1;
        cyc(40);
        chk_digit("lz0_d0", 0, S0, 1'b1);
        chk_digit("lz0_d1", 1, BLK, 1'b1);
        blank_lz = 1'b0;

        // overflow, then recovery
        dp_mask = 4'b1111;
        val = 16'd10000;
        cyc(40);
        chk_digit("ovf_d0", 0, DASH, 1'b1);
        chk_digit("ovf_d1", 1, DASH, 1'b1);
        chk_digit("ovf_d2", 2, DASH, 1'b1);
        chk_digit("ovf_d3", 3, DASH, 1'b1);
        val = 16'd65535;
        cyc(40);
        chk_digit("ovf_max_d1", 1, DASH, 1'b1);
        val = 16'd9999;
        cyc(40);
        chk_digit("v9999_d0", 0, S9, 1'b0);
        chk_digit("v9999_d3", 3, S9, 1'b0);

        // single decimal point
        dp_mask = 4'b0100;
        val = 16'd5000;
        cyc(40);
        chk_digit("dp_d0", 0, S0, 1'b1);
        chk_digit("dp_d1", 1, S0, 1'b1);
        chk_digit("dp_d2", 2, S0, 1'b0);
        chk_digit("dp_d3", 3, S5, 1'b1);

        // val changed during SHIFT is ignored until the next start
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            cyc(1);
            k++;
        end
        if (k >= 40)
            chk("idle_timeout", 32'(busy), 32'd0);
        val = 16'd1234;
        cyc(1);
        val = 16'd5678;
        for (int c = 1; c <= 34; c++) begin
            cyc(1);
            if (c >= 19) begin
                idx = an2idx(anod_select);
                if (idx < 0)
                    chk("toggle_an", 32'(anod_select), 32'hE);
                else
                    chk("toggle_1234", 32'(out), 32'(e1234[idx]));
            end
        end
        cyc(40);
        chk_digit("v5678_d0", 0, S8, 1'b1);
        chk_digit("v5678_d1", 1, S7, 1'b1);
        chk_digit("v5678_d2", 2, S6, 1'b0);
        chk_digit("v5678_d3", 3, S5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment driver for the console's score/timer display. It converts a binary value to BCD with a sequential shift-add-3 converter, holds the result in a display register, and scans DIGITS common-anode digits at a programmable refresh rate. It adds leading-zero blanking, per-digit decimal points and overflow indication, none of which the previous four-digit combinational decoder provided.

## Interface
- DIGITS, 8, number of scanned digits (1..8)
- VAL_W, 27, width of binary input; must satisfy 2^VAL_W ≥ 10^DIGITS − 1 is not required (overflow handled)
- REFRESH_DIV, 65536, clk cycles each digit stays selected (≥2)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- val  in  VAL_W  unsigned value to display, sampled at conversion start
- blank_lz  in  1  1 = blank leading zeros (digit 0 never blanked)
- dp_mask  in  DIGITS  1 = light decimal point of that digit (bit 0 = rightmost)
- out  out  7  segments gfedcba, active-low
- dp  out  1  decimal point, active-low
- anod_select  out  DIGITS  digit enables, active-low, one-hot-zero
- busy  out  1  conversion in progress

## Operation
- Converter FSM: IDLE → SHIFT → COMMIT → IDLE.
  - IDLE: latch val into shift register, clear BCD accumulator (4·DIGITS bits + 4 guard bits), go SHIFT. Restarts every time IDLE is entered; val changes mid-conversion are ignored until next start.
  - SHIFT: VAL_W cycles; each cycle add 3 to every BCD nibble ≥5, then shift left one bit taking val MSB.
  - COMMIT: if any guard nibble bit set or value ≥ 10^DIGITS, set ovf; else copy DIGITS nibbles into display register. One cycle, then IDLE.
- Display register updates only in COMMIT; scan logic never sees partial results.
- Scanner: refresh counter 0..REFRESH_DIV−1; at terminal count digit index increments, wrapping DIGITS−1 → 0.
- Digit decode for selected index i, priority order:
  - ovf: out = 0111111 (dash) on all digits, dp off.
  - blank_lz and i ≠ 0 and nibbles i..DIGITS−1 all zero: out = 1111111.
  - else encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other nibble = 0000110 (E).
  - dp = ~dp_mask[i] unless ovf.
- anod_select = all ones except bit i low.

## Timing
- Reset values: out = 1111111, dp = 1, anod_select = all ones, busy = 0, digit index 0, refresh counter 0, display register 0, ovf 0, FSM IDLE.
- First scan step after reset: anod_select bit 0 goes low on the first clk edge after rst deasserts.
- out, dp, anod_select are registered; they change on the same edge, one cycle after index change — no ghost cycle with old segments on new digit.
- Conversion latency: val sampled in IDLE cycle, display register valid VAL_W+2 cycles later; full period VAL_W+2 cycles.
- busy = 1 in SHIFT and COMMIT.
- blank_lz and dp_mask are combinational into the output register (effective next edge).
- rst asserted mid-conversion or mid-scan: immediate return to reset values; partial conversion discarded.

## Structure
- Package seg7_pkg: segment encoding constants (digits 0–9, DASH, BLANK, ERR), FSM state enum, function seg7_decode(nibble).
- Sub-module bin2bcd_seq (VAL_W, DIGITS): sequential double-dabble with start/done/ovf; scanner and decode in top.

## Test plan
- Reset: rst low mid-run → all outputs reset values within same cycle; release → digit 0 selected next edge.
- DIGITS=4, REFRESH_DIV=4, val=1234 → after VAL_W+2 cycles scan shows 4,3,2,1 on anod 1110,1101,1011,0111, each held 4 cycles, wraps.
- val=7, blank_lz=1 → digit 0 shows 1111000, digits 1–3 blank; blank_lz=0 → digits 1–3 show 1000000; val=0, blank_lz=1 → digit 0 shows 1000000.
- DIGITS=4, val=10000 → ovf: all digits 0111111, dp=1 despite dp_mask=1111; then val=9999 → 9s after next commit.
- dp_mask=0100, val=5000 → dp low only while anod_select=1011.
- val toggles 1234→5678 during SHIFT → display stays 1234 until next COMMIT, then 5678; never mixed digits.
